// File: rtl/round_share_ctrl.sv
// Round-robin controller that time-shares one combinational rounding unit
// among NUM_REQ column requesters and returns results over a valid/ready channel.
module round_share_ctrl #(
  parameter int MANT_WIDTH = 4,
  parameter int EXP_WIDTH  = 3,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ*EXP_WIDTH-1:0]        req_exp,
  input  logic [NUM_REQ*MANT_WIDTH-1:0]       req_mant,
  input  logic [NUM_REQ-1:0]                  req_sign,
  input  logic [NUM_REQ-1:0]                  req_eof,
  output logic [EXP_WIDTH-1:0]                rnd_exp,
  output logic [MANT_WIDTH-1:0]               rnd_mant,
  output logic                                rnd_sign,
  output logic                                rnd_eof,
  input  logic [MANT_WIDTH+EXP_WIDTH:0]       rnd_result,
  input  logic                                rnd_flag,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [ID_W-1:0]                     rsp_id,
  output logic [MANT_WIDTH+EXP_WIDTH:0]       rsp_result,
  output logic                                rsp_flag,
  output logic                                busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [ID_W:0]   NUM_REQ_EXT = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID     = ID_W'(NUM_REQ - 1);

  state_t          state;
  state_t          state_next;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] ptr_next;
  logic            grant_found;
  logic [ID_W:0]   cand;

  // Round-robin search starting at rr_ptr. Gated by rst_n so the grant
  // vector drops together with the asynchronous reset of the state.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    req_ready   = '0;
    grant_id    = '0;
    grant_found = 1'b0;
    cand        = '0;
    if (state == IDLE && rst_n) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
        if (cand >= NUM_REQ_EXT) cand = cand - NUM_REQ_EXT;
        if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
          grant_found = 1'b1;
          grant_id    = cand[ID_W-1:0];
        end
      end
      if (grant_found) req_ready[grant_id] = 1'b1;
    end
  end

  assign ptr_next = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    rsp_valid  = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (grant_found) state_next = ISSUE;
      ISSUE:   state_next = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand registers double as the rnd_* outputs: loaded on grant,
  // held through ISSUE and RESP, cleared when the response is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      rnd_exp    <= '0;
      rnd_mant   <= '0;
      rnd_sign   <= 1'b0;
      rnd_eof    <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_flag   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            rnd_exp  <= req_exp[grant_id*EXP_WIDTH +: EXP_WIDTH];
            rnd_mant <= req_mant[grant_id*MANT_WIDTH +: MANT_WIDTH];
            rnd_sign <= req_sign[grant_id];
            rnd_eof  <= req_eof[grant_id];
            rsp_id   <= grant_id;
            rr_ptr   <= ptr_next;
          end
        end
        ISSUE: begin
          rsp_result <= rnd_result;
          rsp_flag   <= rnd_flag;
        end
        RESP: begin
          if (rsp_ready) begin
            rnd_exp  <= '0;
            rnd_mant <= '0;
            rnd_sign <= 1'b0;
            rnd_eof  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/round_share_ctrl.md
Name: round_share_ctrl

Overview:
- Round-robin scheduler that shares one combinational rounding unit (`round`) among NUM_REQ systolic-array output columns.
- Each column presents a normalised sign/exponent/mantissa plus an EOF flag.
- The controller grants one column at a time, drives the operands into the round unit, registers the packed result and its Round flag, and returns them with the requester ID over a valid/ready response channel.
- Sits between the PE-column normalisers and the result write-back buffer.

Parameters:
- MANT_WIDTH, 4, mantissa width (matches round unit)
- EXP_WIDTH, 3, exponent width (matches round unit)
- NUM_REQ, 4, number of requesting columns (2..16)
- ID_W, $clog2(NUM_REQ), requester ID width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-column request
- req_ready  out  NUM_REQ  one-hot grant; transfer when valid&ready
- req_exp  in  NUM_REQ*EXP_WIDTH  packed NormExp, column i at [i*EXP_WIDTH +: EXP_WIDTH]
- req_mant  in  NUM_REQ*MANT_WIDTH  packed NormMant, same packing
- req_sign  in  NUM_REQ  sign per column
- req_eof  in  NUM_REQ  EOF per column
- rnd_exp  out  EXP_WIDTH  to round unit NormExp
- rnd_mant  out  MANT_WIDTH  to round unit NormMant
- rnd_sign  out  1  to round unit sign_result
- rnd_eof  out  1  to round unit EOF
- rnd_result  in  MANT_WIDTH+EXP_WIDTH+1  from round unit result
- rnd_flag  in  1  from round unit Round
- rsp_valid  out  1  response valid
- rsp_ready  in  1  downstream accept
- rsp_id  out  ID_W  granted column index
- rsp_result  out  MANT_WIDTH+EXP_WIDTH+1  registered rounded word
- rsp_flag  out  1  registered Round flag
- busy  out  1  high when state != IDLE

Behaviour:
- FSM: IDLE -> ISSUE -> RESP -> IDLE.
- Reset: state=IDLE, rr_ptr=0, and every output plus operand, ID, result and flag register = 0.
- IDLE:
  - req_ready is one-hot to the first asserted req_valid, searching from rr_ptr upward modulo NUM_REQ. It is combinational from req_valid and is all-zero when no request is pending.
  - On a grant: capture that column's exp/mant/sign/eof and ID, set rr_ptr=(granted+1) mod NUM_REQ, go to ISSUE.
  - No request: stay in IDLE; rr_ptr unchanged.
- ISSUE:
  - rnd_* driven from the captured registers. rnd_* are registered outputs, stable throughout ISSUE and RESP, and 0 in IDLE.
  - At the clock edge: register rnd_result into rsp_result and rnd_flag into rsp_flag, then go to RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_result and rsp_flag are held stable until rsp_ready.
  - rsp_valid&rsp_ready -> IDLE, and rsp_valid drops in the next cycle.
- Timing:
  - req_ready is asserted only in IDLE.
  - Latency is grant edge + 2 cycles to the first rsp_valid.
  - Minimum issue interval is 3 cycles per result.
- Requesters must hold req_valid and their data stable until granted. A valid that is deasserted before grant is simply not served.
- Simultaneous requests: exactly one grant per IDLE cycle; round-robin guarantees each column is served within NUM_REQ grants.
- Backpressure: rsp_ready low holds RESP indefinitely; no new grant is issued and all req_ready stay 0.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Reset mid-operation (any state): the in-flight transaction is discarded; no response is produced; outputs return to reset values asynchronously.
- No arithmetic inside the block: rounding, exponent increment and the Round flag come entirely from the round unit. Widths pass through unmodified.

Test Plan:
- Single request, MANT_WIDTH=4/EXP_WIDTH=3, column 2: exp=3'b010, mant=4'b1111, sign=0, eof=0.
  - Expect req_ready=4'b0100 in the same cycle.
  - rsp_valid 2 cycles after the grant edge, with rsp_id=2, rsp_result=8'h30, rsp_flag=1.
- EOF pass-through, column 0: exp=3'b111, mant=4'b1010, sign=1, eof=1.
  - Expect rsp_result=8'hFA, rsp_flag=0.
- All four columns request continuously from reset.
  - Grant order 0,1,2,3,0.
  - rsp_id sequence matches, with results issued every 3 cycles and rsp_ready tied high.
- Backpressure: hold rsp_ready=0 for 10 cycles in RESP.
  - rsp_valid, rsp_id, rsp_result and rsp_flag are stable throughout.
  - req_ready=0 throughout; exactly one response on release.
- Wrap and fairness, NUM_REQ=4: column 3 granted, then columns 0 and 3 request together.
  - Column 0 is granted first.
- Reset mid-ISSUE: assert rst_n=0 asynchronously.
  - All outputs are 0 immediately and busy=0.
  - No rsp_valid after rst_n releases.
  - The next grant starts from rr_ptr=0.
